// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: ZF position, datasize codes and REPNE FSM states.
package wb_pkg;

  localparam int WB_ZF_BIT = 6;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_WORD  = 2'd1,
    SZ_DWORD = 2'd2
  } wb_size_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_REP   = 2'd1,
    ST_DRAIN = 2'd2
  } wb_rep_state_e;

  function automatic logic repne_term(input logic count_zero, input logic zf);
    return count_zero | zf;
  endfunction

endpackage

// File: rtl/wb_repne_fsm.sv
// REPNE iteration tracker: detects loop termination, pulses terminate and squashes
// iterations that were already in flight behind the terminating one.
module wb_repne_fsm
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              v_i,
  input  logic              repne_i,
  input  logic              retire_i,
  input  logic              zf_i,
  input  logic [DATA_W-1:0] count_i,
  output logic              squash_o,
  output logic              terminate_o
);

  wb_rep_state_e state_q, state_d;
  logic          term;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    terminate_o = 1'b0;
    squash_o    = 1'b0;
    term        = repne_term(count_i == '0, zf_i);
    unique case (state_q)
      // A non-repne uop retiring inside a loop is not legal; fall back to RUN.
      ST_RUN, ST_REP: begin
        if (retire_i) begin
          if (repne_i) begin
            if (term) begin
              state_d     = ST_DRAIN;
              terminate_o = 1'b1;
            end else begin
              state_d = ST_REP;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_DRAIN: begin
        squash_o = v_i & repne_i;
        if (v_i && !repne_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

endmodule

// File: rtl/writeback_stage_ctrl.sv
// Writeback stage: WB latches, retirement into GPR/flags/count/dcache, EX stall, REPNE FSM.
// Optional perf counters are built when WB_PERF_CNT_EN is defined.
module writeback_stage_ctrl
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DR_W   = 3,
  parameter int ZF_BIT = WB_ZF_BIT
`ifdef WB_PERF_CNT_EN
  ,
  parameter int PERF_W = 32
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WB_ld_latches,
  input  logic              WB_V_next,
  input  logic [DATA_W-1:0] WB_RESULT_A_next,
  input  logic [DATA_W-1:0] WB_RESULT_C_next,
  input  logic [DATA_W-1:0] WB_FLAGS_next,
  input  logic [DR_W-1:0]   WB_DR1_next,
  input  logic [DATA_W-1:0] WB_ADDRESS_next,
  input  logic [1:0]        WB_d2_datasize_all_next,
  input  logic              WB_ex_ld_gpr1_wb_next,
  input  logic              WB_ex_dcache_write_wb_next,
  input  logic              WB_ld_flags_next,
  input  logic              WB_d2_repne_wb_next,
  input  logic              dcache_wr_ready,
  output logic              WB_stall,
  output logic              wb_repne_terminate_all,
  output logic              gpr_we,
  output logic [DR_W-1:0]   gpr_dr,
  output logic [DATA_W-1:0] gpr_data,
  output logic [1:0]        gpr_size,
  output logic              flags_we,
  output logic [DATA_W-1:0] flags_data,
  output logic              count_we,
  output logic [DATA_W-1:0] count_data,
  output logic              dcache_wr_v,
  output logic [DATA_W-1:0] dcache_wr_addr,
  output logic [DATA_W-1:0] dcache_wr_data,
  output logic              retire_v
`ifdef WB_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_retired,
  output logic [PERF_W-1:0] perf_stall_cycles
`endif
);

  logic              v_q;
  logic [DATA_W-1:0] result_a_q, result_c_q, flags_q, address_q;
  logic [DR_W-1:0]   dr1_q;
  wb_size_e          size_q;
  logic              ld_gpr_q, dc_wr_q, ld_flags_q, repne_q;
  logic              squash;

  always_ff @(posedge CLK) begin
    if (RST) begin
      v_q        <= 1'b0;
      result_a_q <= '0;
      result_c_q <= '0;
      flags_q    <= '0;
      address_q  <= '0;
      dr1_q      <= '0;
      size_q     <= SZ_BYTE;
      ld_gpr_q   <= 1'b0;
      dc_wr_q    <= 1'b0;
      ld_flags_q <= 1'b0;
      repne_q    <= 1'b0;
    end else if (WB_ld_latches && !WB_stall) begin
      v_q        <= WB_V_next;
      result_a_q <= WB_RESULT_A_next;
      result_c_q <= WB_RESULT_C_next;
      flags_q    <= WB_FLAGS_next;
      address_q  <= WB_ADDRESS_next;
      dr1_q      <= WB_DR1_next;
      size_q     <= wb_size_e'(WB_d2_datasize_all_next);
      ld_gpr_q   <= WB_ex_ld_gpr1_wb_next;
      dc_wr_q    <= WB_ex_dcache_write_wb_next;
      ld_flags_q <= WB_ld_flags_next;
      repne_q    <= WB_d2_repne_wb_next;
    end
  end

  // Squash is a function of FSM state and the latched uop only, so no loop through retire_v.
  wb_repne_fsm #(
    .DATA_W (DATA_W)
  ) u_repne_fsm (
    .clk_i       (CLK),
    .rst_i       (RST),
    .v_i         (v_q),
    .repne_i     (repne_q),
    .retire_i    (retire_v),
    .zf_i        (flags_q[ZF_BIT]),
    .count_i     (result_c_q),
    .squash_o    (squash),
    .terminate_o (wb_repne_terminate_all)
  );

  assign dcache_wr_v    = v_q & dc_wr_q & ~squash;
  assign WB_stall       = dcache_wr_v & ~dcache_wr_ready;
  assign retire_v       = v_q & ~WB_stall & ~squash;

  assign gpr_we         = retire_v & ld_gpr_q;
  assign gpr_dr         = dr1_q;
  assign gpr_data       = result_a_q;
  assign gpr_size       = size_q;
  assign flags_we       = retire_v & ld_flags_q;
  assign flags_data     = flags_q;
  assign count_we       = retire_v & repne_q;
  assign count_data     = result_c_q;
  assign dcache_wr_addr = address_q;
  assign dcache_wr_data = result_a_q;

`ifdef WB_PERF_CNT_EN
  logic [PERF_W-1:0] perf_retired_q, perf_stall_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_retired_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (retire_v) perf_retired_q <= perf_retired_q + 1'b1;
      if (WB_stall) perf_stall_q   <= perf_stall_q + 1'b1;
    end
  end

  assign perf_retired      = perf_retired_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_writeback_stage_ctrl.sv
// Directed, table-driven bench for writeback_stage_ctrl plus multi-cycle stall/reset sequences.
module tb_writeback_stage_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        WB_ld_latches, WB_V_next;
  logic [31:0] WB_RESULT_A_next, WB_RESULT_C_next, WB_FLAGS_next, WB_ADDRESS_next;
  logic [2:0]  WB_DR1_next;
  logic [1:0]  WB_d2_datasize_all_next;
  logic        WB_ex_ld_gpr1_wb_next, WB_ex_dcache_write_wb_next, WB_ld_flags_next;
  logic        WB_d2_repne_wb_next, dcache_wr_ready;
  logic        WB_stall, wb_repne_terminate_all, gpr_we, flags_we, count_we;
  logic        dcache_wr_v, retire_v;
  logic [2:0]  gpr_dr;
  logic [1:0]  gpr_size;
  logic [31:0] gpr_data, flags_data, count_data, dcache_wr_addr, dcache_wr_data;
`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_retired, perf_stall_cycles;
`endif

  writeback_stage_ctrl #(
    .DATA_W (32),
    .DR_W   (3),
    .ZF_BIT (6)
  ) dut (
    .CLK                        (CLK),
    .RST                        (RST),
    .WB_ld_latches              (WB_ld_latches),
    .WB_V_next                  (WB_V_next),
    .WB_RESULT_A_next           (WB_RESULT_A_next),
    .WB_RESULT_C_next           (WB_RESULT_C_next),
    .WB_FLAGS_next              (WB_FLAGS_next),
    .WB_DR1_next                (WB_DR1_next),
    .WB_ADDRESS_next            (WB_ADDRESS_next),
    .WB_d2_datasize_all_next    (WB_d2_datasize_all_next),
    .WB_ex_ld_gpr1_wb_next      (WB_ex_ld_gpr1_wb_next),
    .WB_ex_dcache_write_wb_next (WB_ex_dcache_write_wb_next),
    .WB_ld_flags_next           (WB_ld_flags_next),
    .WB_d2_repne_wb_next        (WB_d2_repne_wb_next),
    .dcache_wr_ready            (dcache_wr_ready),
    .WB_stall                   (WB_stall),
    .wb_repne_terminate_all     (wb_repne_terminate_all),
    .gpr_we                     (gpr_we),
    .gpr_dr                     (gpr_dr),
    .gpr_data                   (gpr_data),
    .gpr_size                   (gpr_size),
    .flags_we                   (flags_we),
    .flags_data                 (flags_data),
    .count_we                   (count_we),
    .count_data                 (count_data),
    .dcache_wr_v                (dcache_wr_v),
    .dcache_wr_addr             (dcache_wr_addr),
    .dcache_wr_data             (dcache_wr_data),
    .retire_v                   (retire_v)
`ifdef WB_PERF_CNT_EN
    ,
    .perf_retired               (perf_retired),
    .perf_stall_cycles          (perf_stall_cycles)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ld, v, rep, gpr, lf, dcw, rdy;
    logic [31:0] a, c, flags;
    logic [2:0]  dr;
    logic [6:0]  ctrl;   // {stall, term, gpr_we, flags_we, count_we, dcache_wr_v, retire_v}
    logic [2:0]  edr;
    logic [31:0] ea, ec;
  } vec_t;

  int tests  = 0;
  int failed = 0;
  int accepts;
  vec_t tbl[$];

  function automatic vec_t mk(input logic ld, v, rep, gpr, lf, dcw, rdy,
                              input logic [31:0] a, c, flags, input logic [2:0] dr,
                              input logic [6:0] ctrl, input logic [2:0] edr,
                              input logic [31:0] ea, ec);
    vec_t t;
    t.ld = ld; t.v = v; t.rep = rep; t.gpr = gpr; t.lf = lf; t.dcw = dcw; t.rdy = rdy;
    t.a = a; t.c = c; t.flags = flags; t.dr = dr;
    t.ctrl = ctrl; t.edr = edr; t.ea = ea; t.ec = ec;
    return t;
  endfunction

  task automatic drive(input logic ld, v, rep, gpr, lf, dcw, rdy,
                       input logic [31:0] a, c, flags, input logic [2:0] dr,
                       input logic [31:0] addr);
    WB_ld_latches              = ld;
    WB_V_next                  = v;
    WB_d2_repne_wb_next        = rep;
    WB_ex_ld_gpr1_wb_next      = gpr;
    WB_ld_flags_next           = lf;
    WB_ex_dcache_write_wb_next = dcw;
    dcache_wr_ready            = rdy;
    WB_RESULT_A_next           = a;
    WB_RESULT_C_next           = c;
    WB_FLAGS_next              = flags;
    WB_DR1_next                = dr;
    WB_ADDRESS_next            = addr;
    WB_d2_datasize_all_next    = 2'd2;
  endtask

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ctrl_now();
    return {WB_stall, wb_repne_terminate_all, gpr_we, flags_we, count_we, dcache_wr_v, retire_v};
  endfunction

  function automatic logic [191:0] all_out();
    return 192'({WB_stall, wb_repne_terminate_all, gpr_we, gpr_dr, gpr_data, gpr_size,
                 flags_we, flags_data, count_we, count_data, dcache_wr_v,
                 dcache_wr_addr, dcache_wr_data, retire_v});
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // ld v rp gp lf dw rd  A            C      FLAGS  DR | ctrl        eDR eA           eC
    tbl.push_back(mk(1,1,0,1,0,0,1, 32'hDEADBEEF, 0,     0,     3, 7'b0010001, 3, 32'hDEADBEEF, 0));
    tbl.push_back(mk(1,0,0,0,0,0,1, 0,            0,     0,     0, 7'b0000000, 0, 0,            0));
    tbl.push_back(mk(1,1,0,1,1,0,1, 32'h12,       0,     32'h85,5, 7'b0011001, 5, 32'h12,       0));
    tbl.push_back(mk(0,1,0,1,0,0,1, 32'hFFFF,     9,     0,     7, 7'b0011001, 5, 32'h12,       0));
    tbl.push_back(mk(1,1,1,0,0,0,1, 0,            2,     0,     0, 7'b0000101, 0, 0,            2));
    tbl.push_back(mk(1,1,1,0,0,0,1, 0,            1,     0,     0, 7'b0000101, 0, 0,            1));
    tbl.push_back(mk(1,1,1,0,0,0,1, 0,            0,     0,     0, 7'b0100101, 0, 0,            0));
    tbl.push_back(mk(1,1,1,0,0,0,1, 0,            32'hFF,0,     0, 7'b0000000, 0, 0,            32'hFF));
    tbl.push_back(mk(1,1,0,1,0,0,1, 32'hA5,       0,     0,     1, 7'b0010001, 1, 32'hA5,       0));
    tbl.push_back(mk(1,1,1,0,0,0,1, 0,            5,     32'h40,0, 7'b0100101, 0, 0,            5));
    tbl.push_back(mk(1,1,1,0,0,1,0, 0,            4,     0,     0, 7'b0000000, 0, 0,            4));
    tbl.push_back(mk(1,1,1,0,0,0,1, 0,            3,     0,     0, 7'b0000000, 0, 0,            3));
    tbl.push_back(mk(1,1,0,0,1,0,1, 0,            0,     1,     0, 7'b0001001, 0, 0,            0));
    tbl.push_back(mk(1,1,1,0,0,0,1, 0,            3,     0,     0, 7'b0000101, 0, 0,            3));
    tbl.push_back(mk(1,1,0,1,0,0,1, 32'h77,       0,     0,     2, 7'b0010001, 2, 32'h77,       0));
    tbl.push_back(mk(1,1,1,0,0,0,1, 0,            0,     0,     0, 7'b0100101, 0, 0,            0));
    tbl.push_back(mk(1,0,0,0,0,0,1, 0,            0,     0,     0, 7'b0000000, 0, 0,            0));
    tbl.push_back(mk(1,1,1,0,0,0,1, 0,            9,     0,     0, 7'b0000000, 0, 0,            9));
    tbl.push_back(mk(1,1,0,1,0,0,1, 32'h5A,       0,     0,     4, 7'b0010001, 4, 32'h5A,       0));
    tbl.push_back(mk(1,1,1,0,0,0,1, 0,            6,     0,     0, 7'b0000101, 0, 0,            6));
    tbl.push_back(mk(1,1,0,0,0,0,1, 0,            0,     0,     0, 7'b0000001, 0, 0,            0));

    RST = 1'b1;
    drive(0,0,0,0,0,0,1, 0,0,0,0, 0);
    tick();
    tick();
    RST = 1'b0;
    check("reset_outputs", all_out(), '0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ld, tbl[i].v, tbl[i].rep, tbl[i].gpr, tbl[i].lf, tbl[i].dcw, tbl[i].rdy,
            tbl[i].a, tbl[i].c, tbl[i].flags, tbl[i].dr, 0);
      tick();
      check($sformatf("vec%0d_ctrl", i), 192'(ctrl_now()), 192'(tbl[i].ctrl));
      check($sformatf("vec%0d_data", i), 192'({gpr_dr, gpr_data, count_data}),
            192'({tbl[i].edr, tbl[i].ea, tbl[i].ec}));
      if (i == 0) check("vec0_size", 192'(gpr_size), 192'(2'd2));
      if (i == 2) check("vec2_flags", 192'(flags_data), 192'(32'h85));
    end

    // dcache write held off by ready for three cycles, then a single accepted write
    accepts = 0;
    drive(1,1,0,0,0,1,0, 32'hCAFE,0,0,0, 32'h1000);
    tick();
    drive(1,1,0,1,0,0,0, 32'h1111,0,0,6, 0);
    for (int k = 0; k < 3; k++) begin
      if (dcache_wr_v && dcache_wr_ready) accepts++;
      check($sformatf("dc_stall%0d", k), 192'(ctrl_now()), 192'(7'b1000010));
      if (k < 2) tick();
    end
    dcache_wr_ready = 1'b1;
    #1;
    if (dcache_wr_v && dcache_wr_ready) accepts++;
    check("dc_retire_ctrl", 192'(ctrl_now()), 192'(7'b0000011));
    check("dc_retire_data", 192'({dcache_wr_addr, dcache_wr_data}), 192'({32'h1000, 32'hCAFE}));
    tick();
    if (dcache_wr_v && dcache_wr_ready) accepts++;
    check("dc_next_uop", 192'({ctrl_now(), gpr_data}), 192'({7'b0010001, 32'h1111}));
    check("dc_single_write", 192'(accepts), 192'(1));

    // reset while stalled inside a REPNE loop
    drive(1,1,1,0,0,0,1, 0,4,0,0, 0);
    tick();
    check("rstB_enter_rep", 192'(ctrl_now()), 192'(7'b0000101));
    drive(1,1,1,0,0,1,0, 32'hBEEF,3,0,0, 32'h2000);
    tick();
    check("rstB_stalled", 192'(ctrl_now()), 192'(7'b1000010));
    RST = 1'b1;
    drive(1,1,0,1,0,1,0, 32'h3333,0,0,1, 32'h3000);
    tick();
    check("rstB_outputs_zero", all_out(), '0);
    RST = 1'b0;
    WB_ld_latches = 1'b0;
    tick();
    check("rstB_no_dc_write", all_out(), '0);

    // reset out of DRAIN must return to RUN: the next repne uop retires
    drive(1,1,1,0,0,0,1, 0,0,0,0, 0);
    tick();
    check("rstC_terminate", 192'(ctrl_now()), 192'(7'b0100101));
    RST = 1'b1;
    tick();
    RST = 1'b0;
    drive(1,1,1,0,0,0,1, 0,2,0,0, 0);
    tick();
    check("rstC_run_after_rst", 192'({ctrl_now(), count_data}), 192'({7'b0000101, 32'd2}));

`ifdef WB_PERF_CNT_EN
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("perf_reset", 192'({perf_retired, perf_stall_cycles}), '0);
    for (int k = 0; k < 9; k++) begin
      drive(1,1,0,1,0,0,1, 32'(k),0,0,1, 0);
      tick();
    end
    drive(1,1,0,0,0,1,0, 32'h44,0,0,0, 32'h4000);
    tick();
    drive(1,0,0,0,0,0,0, 0,0,0,0, 0);
    repeat (4) @(posedge CLK);
    #1;
    dcache_wr_ready = 1'b1;
    tick();
    check("perf_retired", 192'(perf_retired), 192'(10));
    check("perf_stall_cycles", 192'(perf_stall_cycles), 192'(4));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
